// File: rtl/sel_sequencer.sv
// sel_sequencer: prescaled/stepped select-code generator for a NUM_SEL-input mux.
// Define SEL_SEQ_REVERSE_EN to honour dir (down-count); otherwise it always counts up.
module sel_sequencer #(
  parameter int TICK_DIV = 50000000,
  parameter int NUM_SEL  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       step,
  input  logic       dir,
  input  logic       load,
  input  logic [2:0] load_val,
  output logic [2:0] s,
  output logic       tick,
  output logic       wrap
);
  localparam int CW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [2:0] LAST = 3'(NUM_SEL - 1);
  localparam logic [CW-1:0] CMAX = CW'(TICK_DIV - 1);
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_s;
  logic          r_tick, r_wrap;
  logic          w_end, w_adv, w_wrap;
  logic [2:0]    w_next;
  assign w_end = en & (r_cnt == CMAX);
  assign w_adv = en ? w_end : step;
`ifdef SEL_SEQ_REVERSE_EN
  assign w_wrap = dir ? (r_s == 3'd0) : (r_s == LAST);
  assign w_next = w_wrap ? (dir ? LAST : 3'd0) : (dir ? r_s - 3'd1 : r_s + 3'd1);
`else
  logic w_unused_dir;
  assign w_unused_dir = dir;
  assign w_wrap = r_s == LAST;
  assign w_next = w_wrap ? 3'd0 : r_s + 3'd1;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_s    <= 3'd0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_cnt  <= '0;
      r_s    <= (load_val <= LAST) ? load_val : 3'd0;
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      r_tick <= w_adv;
      r_wrap <= w_adv & w_wrap;
      if (w_adv) r_s <= w_next;
      if (en) r_cnt <= w_end ? '0 : r_cnt + CW'(1);
    end
  end
  assign s    = r_s;
  assign tick = r_tick;
  assign wrap = r_wrap;
endmodule

// File: tb/tb_sel_sequencer.sv
// tb_sel_sequencer: directed stimulus with a tick-driven scoreboard for sel_sequencer.
module tb_sel_sequencer;
  logic       clk = 1'b0, reset = 1'b1, en = 1'b0, step = 1'b0, dir = 1'b0, load = 1'b0;
  logic [2:0] load_val = 3'd0;
  logic [2:0] s;
  logic       tick, wrap;
  logic [3:0] q[$];
  int         total = 0, bad = 0;
  bit         done = 1'b0;

  sel_sequencer #(.TICK_DIV(4), .NUM_SEL(5)) dut (
    .clk(clk), .reset(reset), .en(en), .step(step), .dir(dir), .load(load),
    .load_val(load_val), .s(s), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (!done && !reset && tick) begin
      if (q.size() == 0) chk("unexpected_tick", {1'b0, wrap, s}, 99);
      else chk("tick_s_wrap", {wrap, s}, q.pop_front());
    end
  end

  initial begin
    cyc(2);
    chk("rst_s", s, 0);
    chk("rst_tick", tick, 0);
    chk("rst_wrap", wrap, 0);
    // free-run: advances at edges 4,8,12,16,20
    reset = 1'b0;
    en = 1'b1;
    q.push_back({1'b0, 3'd1});
    q.push_back({1'b0, 3'd2});
    q.push_back({1'b0, 3'd3});
    q.push_back({1'b0, 3'd4});
    q.push_back({1'b1, 3'd0});
    cyc(3);
    chk("free_hold_s", s, 0);
    cyc(17);
    chk("free_end_s", s, 0);
    chk("free_end_wrap", wrap, 1);
    // load mid-count restarts the prescaler
    cyc(2);
    load = 1'b1;
    load_val = 3'd3;
    cyc();
    load = 1'b0;
    chk("load3_s", s, 3);
    chk("load3_tick", tick, 0);
    q.push_back({1'b0, 3'd4});
    cyc(3);
    chk("load3_hold_s", s, 3);
    cyc();
    chk("load3_adv_s", s, 4);
    // out-of-range load
    en = 1'b0;
    load = 1'b1;
    load_val = 3'd6;
    cyc();
    load = 1'b0;
    chk("load6_s", s, 0);
    chk("load6_wrap", wrap, 0);
    chk("load6_tick", tick, 0);
    // manual steps
    for (int i = 1; i <= 3; i++) begin
      q.push_back({1'b0, 3'(i)});
      step = 1'b1;
      cyc();
      step = 1'b0;
      chk("step_s", s, i);
      cyc();
      chk("step_tick_low", tick, 0);
    end
    // step ignored while enabled; cnt still 0 so 4 edges to advance
    en = 1'b1;
    step = 1'b1;
    q.push_back({1'b0, 3'd4});
    cyc(3);
    chk("step_en_ignored", s, 3);
    cyc();
    chk("step_en_adv", s, 4);
    en = 1'b0;
    step = 1'b0;
    cyc();
    // up-wrap on a step from the last code
    q.push_back({1'b1, 3'd0});
    step = 1'b1;
    cyc();
    step = 1'b0;
    chk("step_wrap_s", s, 0);
    // dir=1 step from 0
    dir = 1'b1;
`ifdef SEL_SEQ_REVERSE_EN
    q.push_back({1'b1, 3'd4});
`else
    q.push_back({1'b0, 3'd1});
`endif
    step = 1'b1;
    cyc();
    step = 1'b0;
    dir = 1'b0;
    cyc();
    // async reset mid-count at s=2, cnt=3
    load = 1'b1;
    load_val = 3'd2;
    cyc();
    load = 1'b0;
    en = 1'b1;
    cyc(3);
    chk("pre_rst_s", s, 2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_s", s, 0);
    chk("async_rst_tick", tick, 0);
    #1 reset = 1'b0;
    q.push_back({1'b0, 3'd1});
    cyc(3);
    chk("post_rst_hold_s", s, 0);
    cyc();
    chk("post_rst_adv_s", s, 1);
    en = 1'b0;
    cyc(2);
    done = 1'b1;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sel_sequencer.md
# sel_sequencer

Upstream control stage for the 3-bit 5-to-1 character multiplexer: generates the 3-bit select code `s` that steps the mux through its inputs.
- Free-running mode advances `s` once per prescaled tick; a manual single-step mode and a synchronous load are also provided.
- Output `s` wires directly to the mux select, so the display rotates through the characters on the mux inputs.

## Interface
Parameters:
- `TICK_DIV`, default 50000000 — clock cycles per advance (1 Hz at 50 MHz); legal range 1..2^26.
- `NUM_SEL`, default 5 — number of select codes used, 0..NUM_SEL-1; legal range 2..8.

Ports:
- `clk` input 1 — the single clock; all state updates on its rising edge.
- `reset` input 1 — asynchronous, active-high reset.
- `en` input 1 — 1 = free-running advance; 0 = counting frozen.
- `step` input 1 — single-cycle advance request; honoured only when `en`=0.
- `dir` input 1 — 0 = count up, 1 = count down (see Configuration).
- `load` input 1 — synchronous load of `load_val` into `s`.
- `load_val` input 3 — value to load.
- `s` output 3 — registered select code to the mux.
- `tick` output 1 — registered one-cycle pulse, high in the cycle `s` shows a newly advanced value.
- `wrap` output 1 — registered one-cycle pulse, high when the advance crossed the NUM_SEL-1/0 boundary.

## Operation
- Internal prescaler `cnt`, width ceil(log2(TICK_DIV)) (minimum 1), range 0..TICK_DIV-1.
- Reset values: `s`=0, `cnt`=0, `tick`=0, `wrap`=0.
  - Reset takes effect immediately, independent of `clk`, including mid-count.
- Per-edge priority, highest first:
  - `load`=1: `s` <= `load_val` if `load_val` < NUM_SEL, else 0. `cnt` <= 0; `tick` <= 0; `wrap` <= 0.
  - `en`=1 and `cnt`=TICK_DIV-1: `cnt` <= 0; `s` <= next(`s`); `tick` <= 1; `wrap` <= boundary crossed.
  - `en`=1 otherwise: `cnt` <= `cnt`+1; `tick` <= 0; `wrap` <= 0.
  - `en`=0 and `step`=1: `s` <= next(`s`); `tick` <= 1; `wrap` as above; `cnt` holds.
  - `en`=0 and `step`=0: all state holds; `tick` <= 0; `wrap` <= 0.
- next(`s`), up: NUM_SEL-1 -> 0 with `wrap`; otherwise `s`+1.
- next(`s`), down: 0 -> NUM_SEL-1 with `wrap`; otherwise `s`-1.
- `step` is level-sampled. Holding it high for N cycles advances N times; edge detection is the caller's job.
- `step` while `en`=1 is ignored.
- TICK_DIV=1: advance on every edge with `en`=1; `tick` stays high continuously.

## Timing
- `s`, `tick`, `wrap` are all registered; no combinational path from any input to any output.
- Free-running latency: from the first edge sampling `en`=1 with `cnt`=0, `s` changes on the TICK_DIV-th such edge.
- Step and load latency: 1 cycle, i.e. visible after the sampling edge.
- Deasserting `en` freezes `cnt`; reasserting resumes from the frozen value, with no restart.
- `dir` is sampled on the advancing edge only; changing it between ticks is legal.

## Configuration
- Macro `SEL_SEQ_REVERSE_EN`.
- Defined: `dir` is honoured as specified above.
- Undefined: `dir` is ignored (port kept, left unconnected internally) and the sequencer always counts up; the down-count logic is not synthesised.

## Test plan
All scenarios use TICK_DIV=4, NUM_SEL=5.
- Reset, then `en`=1 held for 20 cycles -> `s` steps 0,1,2,3,4,0 at edges 4,8,12,16,20. `tick` pulses at each of those edges; `wrap`=1 only at edge 20.
- `en`=1, `load`=1 with `load_val`=3 while `cnt`=2 -> next cycle `s`=3, `cnt`=0, `tick`=0. `s`=4 four edges later.
- `load`=1 with `load_val`=6 -> `s`=0, `wrap`=0.
- `en`=0, three single-cycle `step` pulses from `s`=0 -> `s`=1,2,3, one `tick` each, `cnt` unchanged. `step` with `en`=1 has no effect beyond normal counting.
- `SEL_SEQ_REVERSE_EN` defined, `dir`=1, `en`=0, `step` from `s`=0 -> `s`=4, `wrap`=1. Macro undefined, same stimulus -> `s`=1, `wrap`=0.
- `reset` pulsed mid-count (`s`=2, `cnt`=3) between clock edges -> `s`=0, `tick`=0 immediately. After release, the next advance occurs 4 enabled edges later.
